// File: rtl/lsu_subword_ctrl.sv
// Load/store unit adding byte/halfword access over a word-only data memory; loads and SW take 0 cycles,
// SB/SH take a 2-cycle read-modify-write (one stall cycle). Misaligned requests are blocked and logged.
module lsu_subword_ctrl #(
   parameter int FAULT_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   input  logic                   req_we,
   input  logic [2:0]             funct3,
   input  logic [31:0]            addr,
   input  logic [31:0]            store_data,
   output logic [31:0]            load_data,
   output logic                   stall,
   output logic                   misaligned,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_wd,
   output logic                   mem_we,
   input  logic [31:0]            mem_rd,
   input  logic                   fault_clr,
   output logic                   fault_valid,
   output logic [31:0]            fault_addr,
   output logic [FAULT_CNT_W-1:0] fault_count
);

   typedef enum logic {
      IDLE      = 1'b0,
      RMW_WRITE = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            merge_q, merge_d;
   logic [31:0]            addr_q, addr_d;
   logic                   fault_valid_q, fault_valid_d;
   logic [31:0]            fault_addr_q, fault_addr_d;
   logic [FAULT_CNT_W-1:0] fault_count_q, fault_count_d;

   logic        is_byte, is_half, is_word, is_signed;
   logic        f3_valid, req_idle, misalign_raw, access_ok;
   logic        do_load, do_sw, do_sub_st;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] merge_word;

   always_comb begin
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_word   = 1'b0;
      is_signed = 1'b0;
      case (funct3)
         3'b000: begin is_byte = 1'b1; is_signed = 1'b1; end
         3'b001: begin is_half = 1'b1; is_signed = 1'b1; end
         3'b010: is_word = 1'b1;
         3'b100: is_byte = 1'b1;
         3'b101: is_half = 1'b1;
         default: ;
      endcase
   end

   // Requests are only honoured in IDLE; during RMW_WRITE the held request is the one being completed.
   assign f3_valid     = is_byte | is_half | is_word;
   assign req_idle     = (state_q == IDLE) && req_valid && f3_valid;
   assign misalign_raw = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
   assign misaligned   = req_idle && misalign_raw;
   assign access_ok    = req_idle && !misalign_raw;
   assign do_load      = access_ok && !req_we;
   assign do_sw        = access_ok && req_we && is_word;
   assign do_sub_st    = access_ok && req_we && !is_word;

   always_comb begin
      lane_byte = mem_rd[7:0];
      case (addr[1:0])
         2'b00: lane_byte = mem_rd[7:0];
         2'b01: lane_byte = mem_rd[15:8];
         2'b10: lane_byte = mem_rd[23:16];
         2'b11: lane_byte = mem_rd[31:24];
         default: ;
      endcase
      lane_half = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
   end

   always_comb begin
      load_data = 32'h0;
      if (do_load) begin
         if (is_word) begin
            load_data = mem_rd;
         end else if (is_half) begin
            load_data = {{16{is_signed & lane_half[15]}}, lane_half};
         end else begin
            load_data = {{24{is_signed & lane_byte[7]}}, lane_byte};
         end
      end
   end

   always_comb begin
      merge_word = mem_rd;
      if (is_half) begin
         if (addr[1]) merge_word[31:16] = store_data[15:0];
         else         merge_word[15:0]  = store_data[15:0];
      end else begin
         case (addr[1:0])
            2'b00: merge_word[7:0]   = store_data[7:0];
            2'b01: merge_word[15:8]  = store_data[7:0];
            2'b10: merge_word[23:16] = store_data[7:0];
            2'b11: merge_word[31:24] = store_data[7:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      merge_d = merge_q;
      addr_d  = addr_q;
      if (state_q == RMW_WRITE) begin
         state_d = IDLE;
      end else if (do_sub_st) begin
         state_d = RMW_WRITE;
         merge_d = merge_word;
         addr_d  = {addr[31:2], 2'b00};
      end
   end

   // A clear in the same cycle as a fault wins; the fault is not counted.
   always_comb begin
      fault_valid_d = fault_valid_q;
      fault_addr_d  = fault_addr_q;
      fault_count_d = fault_count_q;
      if (fault_clr) begin
         fault_valid_d = 1'b0;
         fault_addr_d  = 32'h0;
         fault_count_d = '0;
      end else if (misaligned) begin
         if (fault_count_q != {FAULT_CNT_W{1'b1}}) begin
            fault_count_d = fault_count_q + FAULT_CNT_W'(1);
         end
         if (!fault_valid_q) begin
            fault_addr_d = addr;
         end
         fault_valid_d = 1'b1;
      end
   end

   always_comb begin
      mem_addr = {addr[31:2], 2'b00};
      mem_wd   = store_data;
      mem_we   = do_sw;
      stall    = do_sub_st;
      if (state_q == RMW_WRITE) begin
         mem_addr = addr_q;
         mem_wd   = merge_q;
         mem_we   = 1'b1;
         stall    = 1'b0;
      end
      if (reset) begin
         mem_we = 1'b0;
         stall  = 1'b0;
      end
   end

   assign fault_valid = fault_valid_q;
   assign fault_addr  = fault_addr_q;
   assign fault_count = fault_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         merge_q       <= 32'h0;
         addr_q        <= 32'h0;
         fault_valid_q <= 1'b0;
         fault_addr_q  <= 32'h0;
         fault_count_q <= '0;
      end else begin
         state_q       <= state_d;
         merge_q       <= merge_d;
         addr_q        <= addr_d;
         fault_valid_q <= fault_valid_d;
         fault_addr_q  <= fault_addr_d;
         fault_count_q <= fault_count_d;
      end
   end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Bench for lsu_subword_ctrl: word memory, per-cycle reference model compare, directed test sequence.
module tb_lsu_subword_ctrl;

   localparam int W = 8;
   localparam int FMAX = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [2:0]    funct3 = 3'b000;
   logic [31:0]   addr = 32'h0;
   logic [31:0]   store_data = 32'h0;
   logic          fault_clr = 1'b0;
   logic [31:0]   load_data, mem_addr, mem_wd, mem_rd, fault_addr;
   logic          stall, misaligned, mem_we, fault_valid;
   logic [W-1:0]  fault_count;

   logic [31:0]   mem [0:255];
   logic [31:0]   ref_mem [0:255];

   int n_chk = 0;
   int n_pass = 0;

   lsu_subword_ctrl #(.FAULT_CNT_W(W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .load_data(load_data), .stall(stall), .misaligned(misaligned),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
      .fault_clr(fault_clr), .fault_valid(fault_valid), .fault_addr(fault_addr),
      .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic [31:0] mask_of(input int sz);
      if (sz >= 4) return 32'hFFFF_FFFF;
      return (32'h1 << (8 * sz)) - 32'h1;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] w, input int off, input int sz, input bit uns);
      logic [31:0] m, v;
      m = mask_of(sz);
      v = (w >> (8 * off)) & m;
      if (!uns && sz < 4 && v[8 * sz - 1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [31:0] merge_of(input logic [31:0] w, input int off, input int sz, input logic [31:0] sd);
      logic [31:0] m;
      m = mask_of(sz);
      return (w & ~(m << (8 * off))) | ((sd & m) << (8 * off));
   endfunction

   bit          m_pend = 0;
   logic [31:0] m_addr = 0, m_word = 0;
   bit          m_fv = 0;
   logic [31:0] m_fa = 0;
   int          m_fc = 0;
   bit          nx_wr = 0, nx_pend = 0, nx_fv = 0;
   logic [7:0]  nx_idx = 0;
   logic [31:0] nx_data = 0, nx_addr = 0, nx_word = 0, nx_fa = 0;
   int          nx_fc = 0;

   always @(negedge clk) begin
      int sz, off;
      bit act, al, e_mis, e_st, e_we;
      logic [31:0] word, e_ld, e_wd, e_ad;
      if (reset) begin
         m_pend = 0; m_fv = 0; m_fa = 0; m_fc = 0;
      end
      sz    = size_of(funct3);
      off   = int'(addr[1:0]);
      act   = !m_pend && req_valid && (sz != 0);
      al    = (sz != 0) && ((off % sz) == 0);
      word  = ref_mem[addr[9:2]];
      e_mis = act && !al;
      e_ld  = (act && al && !req_we) ? load_ext(word, off, sz, funct3[2]) : 32'h0;
      e_st  = !reset && act && al && req_we && (sz < 4);
      e_we  = !reset && (m_pend || (act && al && req_we && sz == 4));
      e_wd  = m_pend ? m_word : store_data;
      e_ad  = m_pend ? m_addr : {addr[31:2], 2'b00};
      chk("cyc load_data", load_data, e_ld);
      chk("cyc stall", {31'h0, stall}, {31'h0, e_st});
      chk("cyc misaligned", {31'h0, misaligned}, {31'h0, e_mis});
      chk("cyc mem_we", {31'h0, mem_we}, {31'h0, e_we});
      chk("cyc mem_wd", mem_wd, e_wd);
      chk("cyc mem_addr", mem_addr, e_ad);
      chk("cyc fault_valid", {31'h0, fault_valid}, {31'h0, m_fv});
      chk("cyc fault_addr", fault_addr, m_fa);
      chk("cyc fault_count", {{(32-W){1'b0}}, fault_count}, m_fc);
      nx_wr = 0; nx_pend = 0;
      nx_fv = m_fv; nx_fa = m_fa; nx_fc = m_fc;
      if (m_pend) begin
         nx_wr = 1; nx_idx = m_addr[9:2]; nx_data = m_word;
      end else if (act && al && req_we) begin
         if (sz == 4) begin
            nx_wr = 1; nx_idx = addr[9:2]; nx_data = store_data;
         end else begin
            nx_pend = 1; nx_addr = {addr[31:2], 2'b00}; nx_word = merge_of(word, off, sz, store_data);
         end
      end
      if (fault_clr) begin
         nx_fv = 0; nx_fa = 0; nx_fc = 0;
      end else if (e_mis) begin
         if (m_fc < FMAX) nx_fc = m_fc + 1;
         if (!m_fv) nx_fa = addr;
         nx_fv = 1;
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         if (nx_wr) ref_mem[nx_idx] = nx_data;
         m_pend = nx_pend; m_addr = nx_addr; m_word = nx_word;
         m_fv = nx_fv; m_fa = nx_fa; m_fc = nx_fc;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, output int n_stall);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; store_data = sd;
      #2;
      n_stall = 0;
      while (stall && n_stall < 4) begin
         @(posedge clk); #3;
         n_stall++;
      end
      if (n_stall >= 4) chk("stall timeout", 32'd1, 32'd0);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000; fault_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int ns;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
         ref_mem[i] = mem[i];
      end
      mem[8'h40] = 32'h8899_AABB;
      ref_mem[8'h40] = 32'h8899_AABB;

      repeat (2) @(posedge clk);
      #3;
      chk("reset stall", {31'h0, stall}, 32'd0);
      chk("reset mem_we", {31'h0, mem_we}, 32'd0);
      chk("reset fault_valid", {31'h0, fault_valid}, 32'd0);
      chk("reset fault_count", {{(32-W){1'b0}}, fault_count}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // loads on 0x8899AABB
      drive(0, 3'b000, 32'h103, 0, ns); chk("LB 0x103", load_data, 32'hFFFF_FF88); chk("LB stall", ns, 0);
      drive(0, 3'b100, 32'h103, 0, ns); chk("LBU 0x103", load_data, 32'h0000_0088); chk("LBU stall", ns, 0);
      drive(0, 3'b001, 32'h102, 0, ns); chk("LH 0x102", load_data, 32'hFFFF_8899); chk("LH stall", ns, 0);
      drive(0, 3'b101, 32'h100, 0, ns); chk("LHU 0x100", load_data, 32'h0000_AABB); chk("LHU stall", ns, 0);
      drive(0, 3'b000, 32'h100, 0, ns); chk("LB 0x100", load_data, 32'hFFFF_FFBB);
      drive(0, 3'b010, 32'h100, 0, ns); chk("LW 0x100", load_data, 32'h8899_AABB);

      // SB read-modify-write
      drive(1, 3'b000, 32'h101, 32'h0000_00EE, ns);
      chk("SB stall cycles", ns, 1);
      chk("SB rmw mem_we", {31'h0, mem_we}, 32'd1);
      idle();
      chk("SB word", mem[8'h40], 32'h8899_EEBB);
      drive(1, 3'b000, 32'h101, 32'h0000_00AA, ns);
      idle();
      chk("SB restore word", mem[8'h40], 32'h8899_AABB);

      // SH then back-to-back SW
      drive(1, 3'b001, 32'h102, 32'h0000_1234, ns); chk("SH stall cycles", ns, 1);
      drive(1, 3'b010, 32'h104, 32'hCAFE_F00D, ns); chk("SW stall cycles", ns, 0);
      idle();
      chk("SH word", mem[8'h40], 32'h1234_AABB);
      chk("SW word", mem[8'h41], 32'hCAFE_F00D);
      drive(0, 3'b001, 32'h100, 0, ns); chk("LH 0x100", load_data, 32'hFFFF_AABB);
      drive(0, 3'b100, 32'h102, 0, ns); chk("LBU 0x102", load_data, 32'h0000_0034);

      // misaligned accesses and fault log
      drive(0, 3'b010, 32'h102, 0, ns);
      chk("LW mis flag", {31'h0, misaligned}, 32'd1);
      chk("LW mis data", load_data, 32'h0);
      drive(1, 3'b001, 32'h101, 32'h0000_5555, ns);
      chk("SH mis flag", {31'h0, misaligned}, 32'd1);
      chk("SH mis stall", ns, 0);
      chk("SH mis we", {31'h0, mem_we}, 32'd0);
      idle();
      chk("mis word", mem[8'h40], 32'h1234_AABB);
      chk("fault_valid", {31'h0, fault_valid}, 32'd1);
      chk("fault_addr", fault_addr, 32'h102);
      chk("fault_count", {{(32-W){1'b0}}, fault_count}, 32'd2);
      @(posedge clk); #1 fault_clr = 1'b1;
      idle();
      #2;
      chk("clr fault_valid", {31'h0, fault_valid}, 32'd0);
      chk("clr fault_addr", fault_addr, 32'h0);
      chk("clr fault_count", {{(32-W){1'b0}}, fault_count}, 32'd0);

      // reset during RMW_WRITE drops the write
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h100; store_data = 32'h0000_00FF;
      #2 chk("SB pre-reset stall", {31'h0, stall}, 32'd1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; req_valid = 1'b0;
      #2;
      chk("post-reset stall", {31'h0, stall}, 32'd0);
      chk("post-reset word", mem[8'h40], 32'h1234_AABB);
      drive(0, 3'b010, 32'h100, 0, ns); chk("LW after reset", load_data, 32'h1234_AABB);

      // invalid funct3 and clear-beats-fault
      drive(0, 3'b011, 32'h100, 0, ns); chk("bad f3 load", load_data, 32'h0);
      drive(1, 3'b111, 32'h101, 32'h0000_0077, ns);
      chk("bad f3 stall", ns, 0);
      chk("bad f3 we", {31'h0, mem_we}, 32'd0);
      @(posedge clk); #1;
      fault_clr = 1'b1; req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h102;
      idle();
      #2;
      chk("clr wins valid", {31'h0, fault_valid}, 32'd0);
      chk("clr wins count", {{(32-W){1'b0}}, fault_count}, 32'd0);

      // counter saturation
      for (int i = 0; i < 300; i++) drive(0, 3'b010, 32'h201 + 32'(i) * 4, 0, ns);
      idle();
      #2;
      chk("sat fault_count", {{(32-W){1'b0}}, fault_count}, 32'hFF);
      chk("sat fault_addr", fault_addr, 32'h201);
      chk("sat fault_valid", {31'h0, fault_valid}, 32'd1);
      idle();
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
